// File: rtl/store_buffer_if.sv
// Store-buffer handshake bundle: store-unit write port,
// memory-bus drain port and load-hazard probe.
interface store_buffer_if;
   logic        in_ready;
   logic        in_write_req;
   logic [31:0] in_addr;
   logic [31:0] in_write_data;
   logic [3:0]  in_byte_enable;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_write_req;
   logic [31:0] load_addr;
   logic        load_hazard;
   logic        empty;

   modport master (
      input  in_ready,
      output in_write_req,
      output in_addr,
      output in_write_data,
      output in_byte_enable,
      output bus_ready,
      input  bus_addr,
      input  bus_write_data,
      input  bus_byte_enable,
      input  bus_write_req,
      output load_addr,
      input  load_hazard,
      input  empty
   );

   modport slave (
      output in_ready,
      input  in_write_req,
      input  in_addr,
      input  in_write_data,
      input  in_byte_enable,
      input  bus_ready,
      output bus_addr,
      output bus_write_data,
      output bus_byte_enable,
      output bus_write_req,
      input  load_addr,
      output load_hazard,
      output empty
   );
endinterface

// File: rtl/store_buffer.sv
// In-order word write FIFO between the store unit and the
// data-memory bus, with a same-word load hazard flag.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          reset_n,
   store_buffer_if.slave sb_io
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   localparam cnt_t FULL = cnt_t'(DEPTH);

   logic [29:0] addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [3:0]  be_q   [DEPTH];

   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   cnt_t count_q, count_d;

   logic push;
   logic pop;
   logic hazard;
   logic unused_lsbs;

   assign unused_lsbs = ^{sb_io.in_addr[1:0],
                          sb_io.load_addr[1:0]};

   // Full buffer never passes a push through on a same-cycle pop.
   assign sb_io.in_ready      = (count_q != FULL);
   assign sb_io.bus_write_req = (count_q != '0);
   assign sb_io.empty         = (count_q == '0);

   // A zero byte-enable write completes the handshake but is dropped.
   assign push = sb_io.in_write_req && sb_io.in_ready
              && (sb_io.in_byte_enable != 4'h0);
   assign pop  = sb_io.bus_write_req && sb_io.bus_ready;

   assign sb_io.bus_addr        = {addr_q[rd_ptr_q], 2'b00};
   assign sb_io.bus_write_data  = data_q[rd_ptr_q];
   assign sb_io.bus_byte_enable = be_q[rd_ptr_q];
   assign sb_io.load_hazard     = hazard;

   always_comb begin
      rd_ptr_d = rd_ptr_q + ptr_t'(pop);
      wr_ptr_d = wr_ptr_q + ptr_t'(push);
      count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
   end

   // Entry i is resident when its distance from rd_ptr is below count.
   always_comb begin
      ptr_t off;
      hazard = 1'b0;
      off    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = ptr_t'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) &&
             (addr_q[i] == sb_io.load_addr[31:2]))
            hazard = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            addr_q[wr_ptr_q] <= sb_io.in_addr[31:2];
            data_q[wr_ptr_q] <= sb_io.in_write_data;
            be_q[wr_ptr_q]   <= sb_io.in_byte_enable;
         end
      end
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular write FIFO sitting directly downstream of the CPU store unit; accepts its aligned word writes (addr/data/byte-enable) through a req/ready handshake.
- Decouples store-unit progress from memory-bus stalls.
- Drains queued writes in order onto the data-memory bus.
- Provides a load-hazard flag so the load path stalls while a pending store targets the same word.

Parameters:
DEPTH, 4, number of buffered word writes; power of two, >= 2.

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
in_ready  output  1  buffer can accept a write this cycle
in_write_req  input  1  upstream write request; held until accepted
in_addr  input  32  word address; bits [1:0] ignored, stored as 0
in_write_data  input  32  write data
in_byte_enable  input  4  byte lanes to write
bus_ready  input  1  memory accepts the presented write this cycle
bus_addr  output  32  head entry address, [1:0] = 0
bus_write_data  output  32  head entry data
bus_byte_enable  output  4  head entry byte enables
bus_write_req  output  1  head entry valid
load_addr  input  32  address of the load being issued
load_hazard  output  1  a buffered write targets load_addr's word
empty  output  1  no buffered writes; used for fences

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Storage: DEPTH-entry circular buffer of {addr[31:2], data, be}.
  - Pointers: rd_ptr and wr_ptr, clog2(DEPTH) bits each, wrapping naturally.
  - Occupancy: count, clog2(DEPTH)+1 bits.
- Reset: count = 0, pointers = 0, all entry fields = 0.
  - Outputs after reset: bus_write_req = 0, bus_addr = 0, bus_write_data = 0, bus_byte_enable = 0, in_ready = 1, empty = 1, load_hazard = 0.
  - Reset mid-operation discards all pending writes; no partial drain.
- in_ready = (count != DEPTH). It is a function of count only.
  - A pop in the same cycle does NOT free a slot for a push when full (no full pass-through).
- Push: in_write_req && in_ready.
  - If in_byte_enable != 0: entry written at wr_ptr, wr_ptr++, count++ (unless also popping).
  - If in_byte_enable == 0: handshake completes and the write is dropped; no state change.
- Bus side:
  - bus_write_req = (count != 0).
  - bus_addr/bus_write_data/bus_byte_enable = entry[rd_ptr] (flop outputs through a mux; no combinational path from in_*). When empty, the fields hold the last-read slot contents; consumers ignore them.
- Pop: bus_write_req && bus_ready; rd_ptr++, count-- (unless also pushing).
  - bus_write_req stays high and the fields stay stable until bus_ready.
- Simultaneous push and pop (count not 0, not DEPTH): count unchanged, both pointers advance.
- Latency: a write accepted while empty appears on bus_* the next cycle. It cannot bypass in the acceptance cycle.
- Ordering: strict FIFO; no coalescing or reordering.
- load_hazard (combinational):
  - Asserted when any valid resident entry has addr[31:2] == load_addr[31:2]; byte enables are not compared.
  - An entry is valid if its index lies in [rd_ptr, rd_ptr+count) modulo DEPTH.
  - Includes the head entry even if it is being popped this cycle.
  - Excludes the write being pushed this cycle.
- empty = (count == 0).

Test Plan:
- Reset then single write addr 0x1000_0006, data 0xDEADBEEF, be 0xC, bus_ready = 1 -> next cycle bus_write_req = 1, bus_addr 0x1000_0004, data 0xDEADBEEF, be 0xC; empty returns to 1 one cycle later.
- bus_ready = 0; push 5 writes back-to-back (DEPTH = 4) -> in_ready drops after 4th accept; 5th held; raise bus_ready -> drained in push order with no loss or duplication; 5th accepted one cycle after first pop.
- Full buffer plus in_write_req plus bus_ready same cycle -> pop occurs, push refused (in_ready = 0), count = 3; push accepted next cycle.
- Steady stream with bus_ready toggling 1/0 every cycle over 20 writes, wrap-around of pointers -> bus sequence equals input sequence exactly; count never exceeds 4.
- Buffer holds 0x2000_0010; load_addr 0x2000_0013 -> load_hazard = 1; load_addr 0x2000_0014 -> 0; after that entry pops -> 0; write with be = 0 -> accepted, never appears on bus.
- Three writes pending, assert reset_n = 0 one cycle -> bus_write_req = 0, empty = 1, in_ready = 1, load_hazard = 0 next cycle.
